// File: rtl/adc_eth_framer.sv
// Packs a 16-bit ADC sample stream into raw Ethernet frames (header, 32-bit sequence
// number, fixed payload) on a byte-wide AXI-stream toward the MAC; starvation aborts the frame.
module adc_eth_framer #(
  parameter int          PAYLOAD_BYTES = 1024,
  parameter logic [47:0] DST_MAC       = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC       = 48'h02_00_00_00_00_01,
  parameter logic [15:0] ETHERTYPE     = 16'h88B5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] s_sample_tdata,
  input  logic        s_sample_tvalid,
  output logic        s_sample_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic [31:0] seq_num,
  output logic [15:0] abort_count,
  output logic        busy
);

  localparam int SAMPLES  = PAYLOAD_BYTES / 2;
  localparam int CW       = $clog2(SAMPLES + 1);
  localparam int HDR_LAST = 17;

  typedef enum logic [1:0] {IDLE, HDR, PAY_HI, PAY_LO} state_t;

  // Valid/ready: a beat transfers on a clock edge where valid and ready are both high;
  // valid, once raised, holds data/last/user stable until that edge.
  state_t          state;
  state_t          state_d;

  logic            slot_free;
  logic            start;
  logic            load;
  logic            take;
  logic            abort_evt;
  logic            last_sample;
  logic [7:0]      load_data;
  logic            load_last;
  logic            load_user;

  logic [4:0]      idx;
  logic [CW-1:0]   sample_cnt;
  logic [7:0]      lsb_hold;
  logic [31:0]     seq_q;
  logic [31:0]     frame_seq;
  logic [15:0]     abort_q;
  logic [7:0]      tdata_q;
  logic            tvalid_q;
  logic            tlast_q;
  logic            tuser_q;

  logic [143:0]    hdr_vec;
  logic [7:0]      hdr_arr [32];

  // Header bytes for the frame in flight, byte 0 first; entries past 17 are never selected.
  assign hdr_vec = {DST_MAC, SRC_MAC, ETHERTYPE, frame_seq};

  for (genvar g = 0; g < 32; g++) begin : g_hdr
    if (g <= HDR_LAST) begin : g_used
      assign hdr_arr[g] = hdr_vec[143 - 8*g -: 8];
    end else begin : g_unused
      assign hdr_arr[g] = 8'h00;
    end
  end

  assign slot_free   = !tvalid_q || m_axis_tready;
  assign last_sample = (sample_cnt == CW'(SAMPLES));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE:   if (slot_free && enable && s_sample_tvalid) state_d = HDR;
      HDR:    if (slot_free && idx == 5'(HDR_LAST))       state_d = PAY_HI;
      PAY_HI: if (slot_free) state_d = s_sample_tvalid ? PAY_LO : IDLE;
      PAY_LO: if (slot_free) state_d = last_sample ? IDLE : PAY_HI;
      default: state_d = IDLE;
    endcase
  end

  // Output / control decode: what (if anything) enters the byte slot this cycle
  always_comb begin
    start           = 1'b0;
    load            = 1'b0;
    take            = 1'b0;
    abort_evt       = 1'b0;
    load_data       = 8'h00;
    load_last       = 1'b0;
    load_user       = 1'b0;
    s_sample_tready = 1'b0;
    case (state)
      IDLE: begin
        if (slot_free && enable && s_sample_tvalid) begin
          start     = 1'b1;
          load      = 1'b1;
          load_data = DST_MAC[47:40];
        end
      end
      HDR: begin
        if (slot_free) begin
          load      = 1'b1;
          load_data = hdr_arr[idx];
        end
      end
      PAY_HI: begin
        if (slot_free) begin
          s_sample_tready = 1'b1;
          load            = 1'b1;
          if (s_sample_tvalid) begin
            take      = 1'b1;
            load_data = s_sample_tdata[15:8];
          end else begin
            // Starved: close the frame with a bad-frame marker rather than stall the MAC.
            abort_evt = 1'b1;
            load_data = 8'h00;
            load_last = 1'b1;
            load_user = 1'b1;
          end
        end
      end
      PAY_LO: begin
        if (slot_free) begin
          load      = 1'b1;
          load_data = lsb_hold;
          load_last = last_sample;
        end
      end
      default: ;
    endcase
  end

  // Output byte slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdata_q  <= 8'h00;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
    end else if (load) begin
      tdata_q  <= load_data;
      tvalid_q <= 1'b1;
      tlast_q  <= load_last;
      tuser_q  <= load_user;
    end else if (m_axis_tready) begin
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
    end
  end

  // Frame bookkeeping: header index, sample count, held LSB, sequence and abort counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= 5'd0;
      sample_cnt <= '0;
      lsb_hold   <= 8'h00;
      seq_q      <= 32'h0;
      frame_seq  <= 32'h0;
      abort_q    <= 16'h0;
    end else begin
      if (start) begin
        idx        <= 5'd1;
        sample_cnt <= '0;
        frame_seq  <= seq_q;
        seq_q      <= seq_q + 32'd1;
      end else if (state == HDR && slot_free) begin
        idx <= idx + 5'd1;
      end
      if (take) begin
        lsb_hold   <= s_sample_tdata[7:0];
        sample_cnt <= sample_cnt + CW'(1);
      end
      if (abort_evt && abort_q != 16'hFFFF) abort_q <= abort_q + 16'd1;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign seq_num       = seq_q;
  assign abort_count   = abort_q;
  assign busy          = (state != IDLE) || tvalid_q;

endmodule

// File: tb/tb_adc_eth_framer.sv
// Bench for adc_eth_framer: a queue-based frame model builds the expected byte stream from
// the samples handed to the source; a monitor compares every accepted beat against it.
module tb_adc_eth_framer;

  localparam int          W         = 10;  // {tuser, tlast, tdata}
  localparam int          NSAMP     = 512;
  localparam logic [47:0] DST       = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SRC       = 48'h02_00_00_00_00_01;
  localparam logic [15:0] ETYPE     = 16'h88B5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] s_sample_tdata;
  logic        s_sample_tvalid;
  logic        s_sample_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic [31:0] seq_num;
  logic [15:0] abort_count;
  logic        busy;

  adc_eth_framer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .s_sample_tdata  (s_sample_tdata),
    .s_sample_tvalid (s_sample_tvalid),
    .s_sample_tready (s_sample_tready),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tuser    (m_axis_tuser),
    .seq_num         (seq_num),
    .abort_count     (abort_count),
    .busy            (busy)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int           checks   = 0;
  int           failures = 0;
  int           cyc      = 0;
  int           frames_started = 0;
  bit           tready_rand = 1'b0;
  logic [W-1:0] exp_q[$];
  logic [15:0]  src_q[$];
  logic [15:0]  mdl_q[$];
  int           start_cyc_q[$];
  int           last_cyc_q[$];

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Driver tasks and frame model
  task automatic push_sample(input logic [15:0] s);
    src_q.push_back(s);
    mdl_q.push_back(s);
  endtask

  task automatic model_frame(input logic [31:0] seq, input int n, input bit abort);
    logic [15:0] s;
    for (int i = 0; i < 6; i++) exp_q.push_back({2'b00, 8'(DST >> (8*(5-i)))});
    for (int i = 0; i < 6; i++) exp_q.push_back({2'b00, 8'(SRC >> (8*(5-i)))});
    for (int i = 0; i < 2; i++) exp_q.push_back({2'b00, 8'(ETYPE >> (8*(1-i)))});
    for (int i = 0; i < 4; i++) exp_q.push_back({2'b00, 8'(seq >> (8*(3-i)))});
    for (int i = 0; i < n; i++) begin
      s = mdl_q.pop_front();
      exp_q.push_back({2'b00, s[15:8]});
      exp_q.push_back({1'b0, (!abort && i == n-1), s[7:0]});
    end
    if (abort) exp_q.push_back({2'b11, 8'h00});
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Source driver + output monitor (sampling on the falling edge, driving #1 after rising)
  initial begin : drv_mon
    bit           in_fire;
    bit           in_frame   = 1'b0;
    bit           prev_stall = 1'b0;
    logic [W+0:0] prev_word  = '0;
    logic [W-1:0] got;
    forever begin
      @(negedge clk);
      cyc++;
      in_fire = s_sample_tvalid && s_sample_tready;
      if (!rst_n) begin
        in_frame   = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall)
          chk("hold_stable", 32'({m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}),
              32'(prev_word));
        if (in_frame) chk("no_valid_drop", 32'(m_axis_tvalid), 32'd1);
        if (m_axis_tvalid && m_axis_tready) begin
          if (!in_frame) begin
            start_cyc_q.push_back(cyc);
            frames_started++;
          end
          got = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
          chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) chk("beat", 32'(got), 32'(exp_q.pop_front()));
          in_frame = !m_axis_tlast;
          if (m_axis_tlast) last_cyc_q.push_back(cyc);
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_word  = {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata};
      end
      @(posedge clk);
      #1;
      if (in_fire && rst_n && src_q.size() != 0) void'(src_q.pop_front());
      s_sample_tvalid = (src_q.size() != 0);
      s_sample_tdata  = (src_q.size() != 0) ? src_q[0] : 16'h0000;
      m_axis_tready   = tready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Directed sequence
  initial begin
    int n;
    rst_n = 1'b0; enable = 1'b0;
    s_sample_tvalid = 1'b0; s_sample_tdata = 16'h0; m_axis_tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tdata", 32'(m_axis_tdata), 32'd0);
    chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
    chk("rst_tuser", 32'(m_axis_tuser), 32'd0);
    chk("rst_sready", 32'(s_sample_tready), 32'd0);
    chk("rst_seq", seq_num, 32'd0);
    chk("rst_abort", 32'(abort_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Ramp frame, MAC always ready
    for (int i = 0; i < NSAMP; i++) push_sample(16'(i));
    model_frame(32'd0, NSAMP, 1'b0);
    enable = 1'b1;
    wait_drain("ramp", 3000);
    chk("ramp_seq", seq_num, 32'd1);
    chk("ramp_tuser_idle", 32'(busy), 32'd0);

    // Two back-to-back frames of random samples
    @(posedge clk); #1;
    start_cyc_q.delete(); last_cyc_q.delete();
    for (int i = 0; i < 2*NSAMP; i++) push_sample(16'($urandom));
    model_frame(32'd1, NSAMP, 1'b0);
    model_frame(32'd2, NSAMP, 1'b0);
    wait_drain("b2b", 5000);
    chk("b2b_frames", 32'(start_cyc_q.size()), 32'd2);
    if (start_cyc_q.size() == 2 && last_cyc_q.size() >= 1)
      chk("b2b_gap", 32'(start_cyc_q[1]), 32'(last_cyc_q[0] + 1));
    chk("b2b_seq", seq_num, 32'd3);

    // Ramp frame under random MAC backpressure
    @(posedge clk); #1;
    tready_rand = 1'b1;
    for (int i = 0; i < NSAMP; i++) push_sample(16'(i));
    model_frame(32'd3, NSAMP, 1'b0);
    wait_drain("bp", 8000);
    tready_rand = 1'b0;
    chk("bp_seq", seq_num, 32'd4);

    // Starvation after 10 samples
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) push_sample(16'($urandom));
    model_frame(32'd4, 10, 1'b1);
    wait_drain("abort", 300);
    chk("abort_count", 32'(abort_count), 32'd1);
    chk("abort_seq", seq_num, 32'd5);

    // Enable dropped right after a frame starts; extra samples must stay unconsumed
    @(posedge clk); #1;
    enable = 1'b0;
    for (int i = 0; i < NSAMP; i++) push_sample(16'($urandom));
    model_frame(32'd5, NSAMP, 1'b0);
    n = frames_started;
    enable = 1'b1;
    for (int k = 0; k < 50 && frames_started == n; k++) @(negedge clk);
    chk("en_started", 32'(frames_started), 32'(n + 1));
    @(posedge clk); #1;
    enable = 1'b0;
    for (int i = 0; i < 4; i++) src_q.push_back(16'($urandom));
    wait_drain("en_off", 3000);
    repeat (10) @(negedge clk);
    chk("en_off_sready", 32'(s_sample_tready), 32'd0);
    chk("en_off_busy", 32'(busy), 32'd0);
    chk("en_off_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("en_off_pending", 32'(src_q.size()), 32'd4);
    chk("en_off_seq", seq_num, 32'd6);
    @(posedge clk); #1;
    src_q.delete();

    // Sequence number wrap
    @(negedge clk);
    force dut.seq_q = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.seq_q;
    @(negedge clk);
    chk("wrap_preload", seq_num, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    for (int i = 0; i < NSAMP; i++) push_sample(16'($urandom));
    model_frame(32'hFFFF_FFFF, NSAMP, 1'b0);
    enable = 1'b1;
    wait_drain("wrap", 3000);
    chk("wrap_seq", seq_num, 32'd0);

    // Reset in the middle of a frame
    @(posedge clk); #1;
    for (int i = 0; i < NSAMP; i++) push_sample(16'($urandom));
    model_frame(32'd0, NSAMP, 1'b0);
    repeat (100) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_seq", seq_num, 32'd0);
    chk("mid_rst_abort", 32'(abort_count), 32'd0);
    chk("mid_rst_sready", 32'(s_sample_tready), 32'd0);
    exp_q.delete(); src_q.delete(); mdl_q.delete();
    @(posedge clk); #1;
    enable = 1'b0;
    rst_n  = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_eth_framer.md
# adc_eth_framer

Packs a continuous 16-bit ADC sample stream into raw Ethernet frames. It drives the byte-wide AXI-stream transmit input of the 1G MAC (`tx_axis_*`) and is the writer side of that interface. Each frame carries a fixed header, a 32-bit sequence number and a fixed-size payload of samples. The MAC appends preamble, padding and FCS. Mid-frame sample starvation aborts the frame with an explicit bad-frame marker instead of stalling the MAC into underflow.

## Interface
Parameters:
- `PAYLOAD_BYTES`, 1024: payload bytes per frame. Must be even and ≥ 46. Samples per frame = PAYLOAD_BYTES/2.
- `DST_MAC`, 48'hFFFF_FFFF_FFFF: destination MAC, sent MSB first.
- `SRC_MAC`, 48'h02_00_00_00_00_01: source MAC, sent MSB first.
- `ETHERTYPE`, 16'h88B5: EtherType, sent MSB first.

Ports:
- `clk` in 1: single clock; all logic is in this domain.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `enable` in 1: permits new frames to start.
- `s_sample_tdata` in 16: ADC sample.
- `s_sample_tvalid` in 1: sample valid.
- `s_sample_tready` out 1: sample accepted when high together with tvalid.
- `m_axis_tdata` out 8: frame byte to the MAC.
- `m_axis_tvalid` out 1: byte valid.
- `m_axis_tready` in 1: MAC accepts the byte.
- `m_axis_tlast` out 1: last byte of the frame.
- `m_axis_tuser` out 1: bad-frame marker, valid with tlast.
- `seq_num` out 32: sequence number of the next frame to start.
- `abort_count` out 16: aborted frames, saturates at 16'hFFFF.
- `busy` out 1: high while a frame is in progress (state ≠ IDLE or output register valid).

## Operation
- Frame byte order:
  - DST_MAC (6 bytes)
  - SRC_MAC (6 bytes)
  - ETHERTYPE (2 bytes)
  - seq_num (4 bytes, MSB first; 18-byte header)
  - payload samples, each sent MSB byte then LSB byte.
- Total frame length is 18 + PAYLOAD_BYTES bytes (1042 at default).
- Output register: there is one registered byte slot. The slot is free when `!m_axis_tvalid || m_axis_tready`. A new byte loads only when the slot is free.
- States:
  - IDLE: if `enable && s_sample_tvalid` and the slot is free, load header byte 0, latch `seq_num` into a frame copy, increment `seq_num` (wraps 32'hFFFFFFFF→0), and go to HDR with idx=1. A sample is not consumed here.
  - HDR: load header byte idx each free slot. After byte 17 is loaded, go to PAY_HI.
  - PAY_HI, slot free:
    - If `s_sample_tvalid`: `s_sample_tready`=1 (combinational: state==PAY_HI && slot free). Load the MSB byte, hold the LSB byte, go to PAY_LO.
    - Else (abort): load 8'h00 with tlast=1 and tuser=1, increment `abort_count` (saturating), go to IDLE.
  - PAY_LO, slot free: load the held LSB byte. If it is the final sample, tlast=1, tuser=0, go to IDLE. Otherwise go to PAY_HI.
- `s_sample_tready` is 0 in every state other than PAY_HI.
- Deasserting `enable` mid-frame has no effect on the current frame. It only blocks the next start.
- Samples that arrive in IDLE while `enable`=0 are not consumed; upstream is backpressured.

## Timing
- Reset values: `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tlast`=0, `m_axis_tuser`=0, `s_sample_tready`=0, `seq_num`=0, `abort_count`=0, `busy`=0, state=IDLE.
- Start latency: the start condition is true at edge N; `m_axis_tvalid`=1 with byte 0 from after edge N.
- Throughput: 1 byte per cycle while `m_axis_tready`=1. A frame takes exactly 18+PAYLOAD_BYTES accepted beats. One sample is accepted every 2 beats.
- Once started, `m_axis_tvalid` never drops until tlast is accepted, provided samples keep up. The MAC therefore never sees an underflow.
- Back-to-back frames: IDLE can start the next frame on the same edge that tlast is accepted. There is no idle gap; the MAC inserts the IFG.
- `m_axis_tready` low holds data/last/user stable. Abort evaluation happens only when the slot is free, so a sample arriving during backpressure avoids the abort.
- Reset mid-frame clears everything immediately. The partial frame is dropped without tlast; the MAC-side reset is the system's responsibility.

## Test plan
- Reset, then `enable`=1, ramp samples 16'h0000..16'h01FF always valid, `m_axis_tready`=1. Required: 1042 beats. Bytes 0–5 FF, 6–11 02 00 00 00 00 01, 12–13 88 B5, 14–17 00 00 00 00. Payload 00 00 00 01 … 01 FF. tlast on beat 1041 only, tuser=0, `seq_num`=1.
- Two frames back-to-back. Required: second frame bytes 14–17 = 00 00 00 01, first byte of frame 2 valid on the cycle after frame 1 tlast is accepted.
- Random `m_axis_tready` (50%). Required: identical byte stream to the first scenario, no tvalid drop mid-frame, data stable while tready=0.
- Drop `s_sample_tvalid` after 10 samples. Required: byte 38 = 8'h00 with tlast=1, tuser=1, `abort_count`=1, next frame has seq 1.
- `enable`=0 after frame start. Required: frame completes normally, no new frame, `s_sample_tready`=0, `busy`=0 after tlast.
- Preload `seq_num` path to 32'hFFFFFFFF (force), send a frame. Required: header seq FF FF FF FF, `seq_num` wraps to 0.
